// File: rtl/game_pkg.sv
// Shared definitions for the game round sequencer.
//
// Contents:
//   phase_t            - round phase encoding, also driven on the phase output
//   DEF_COUNTDOWN_SECS - default countdown length in 1 Hz ticks
//   DEF_PLAY_SECS      - default play window length in 1 Hz ticks
package game_pkg;

  typedef enum logic [1:0] {
    PH_COUNTDOWN = 2'b00,
    PH_PLAY      = 2'b01,
    PH_OVER      = 2'b10,
    PH_UNUSED    = 2'b11
  } phase_t;

  localparam int DEF_COUNTDOWN_SECS = 5;
  localparam int DEF_PLAY_SECS      = 30;

endpackage

// File: rtl/sec_down_counter.sv
// Loadable 8-bit seconds down-counter with a tick enable.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset, loads RESET_VAL
//   tick       - decrement enable (one-clk pulse per second)
//   load       - load load_val; wins over tick
//   load_val   - value loaded when load is high
//   count      - registered counter value
//   count_next - value count takes on the next edge (lets the parent
//                register a copy of the count in step with it)
//   is_one     - count == 1, i.e. the next tick ends the phase
module sec_down_counter #(
  parameter logic [7:0] RESET_VAL = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic [7:0] count_next,
  output logic       is_one
);

  // Decrement that holds at zero instead of wrapping to 255.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (tick) begin
      count_next = sat_dec(count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else begin
      count <= count_next;
    end
  end

  assign is_one = (count == 8'd1);

endmodule

// File: rtl/game_phase_sequencer.sv
// Game round sequencer: countdown -> play window -> final-score hold.
// All timing comes from the 1 Hz tick enable; every output is registered.
//
// Optional feature: define GAME_HIGH_SCORE_EN to keep a best-score register
// and make the OVER display alternate final/high score on every tick.
// Without it high_score is tied to zero and OVER shows only the final score.
//
// Ports:
//   clk           - 100 MHz system clock
//   reset         - synchronous active-high reset (aborts the round)
//   tick_1hz      - one-clk pulse per second
//   start         - one-clk restart request, honoured only in OVER
//   score_in      - live score from the score counter
//   phase         - 00 COUNTDOWN, 01 PLAY, 10 OVER
//   time_left     - seconds left in the timed phase, 0 in OVER
//   display_value - value for the BCD converter
//   score_clear   - one-cycle pulse that zeroes the score counter
//   score_enable  - score counter may increment
//   led_enable    - mole LEDs visible
//   round_done    - one-cycle pulse on entry to OVER
//   high_score    - best score so far (zero when the feature is disabled)
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int COUNTDOWN_SECS = DEF_COUNTDOWN_SECS,
  parameter int PLAY_SECS      = DEF_PLAY_SECS,
  parameter int SCORE_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic [SCORE_W-1:0] score_in,
  output logic [1:0]         phase,
  output logic [7:0]         time_left,
  output logic [SCORE_W-1:0] display_value,
  output logic               score_clear,
  output logic               score_enable,
  output logic               led_enable,
  output logic               round_done,
  output logic [SCORE_W-1:0] high_score
);

  localparam logic [7:0] CD_LOAD = 8'(COUNTDOWN_SECS);
  localparam logic [7:0] PL_LOAD = 8'(PLAY_SECS);

  phase_t             phase_q, phase_d;
  logic               cnt_tick, cnt_load, cnt_is_one;
  logic [7:0]         cnt_load_val, cnt_q, cnt_next;
  logic [SCORE_W-1:0] final_q, final_d;
  logic [SCORE_W-1:0] display_q, display_d;
  logic               score_clear_q, score_clear_d;
  logic               round_done_q, round_done_d;
  logic               play_q;

`ifdef GAME_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;
  logic               show_high_q, show_high_d;
`endif

  sec_down_counter #(
    .RESET_VAL (CD_LOAD)
  ) u_sec_cnt (
    .clk        (clk),
    .reset      (reset),
    .tick       (cnt_tick),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .count      (cnt_q),
    .count_next (cnt_next),
    .is_one     (cnt_is_one)
  );

  // Next-state and next-output logic
  always_comb begin
    phase_d       = phase_q;
    cnt_tick      = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = 8'd0;
    score_clear_d = 1'b0;
    round_done_d  = 1'b0;
    final_d       = final_q;
`ifdef GAME_HIGH_SCORE_EN
    // The final score lands in final_q on entry to OVER, so the comparison
    // is made one cycle later, while round_done is showing.
    high_d        = (round_done_q && (final_q > high_q)) ? final_q : high_q;
    show_high_d   = show_high_q;
`endif

    case (phase_q)
      PH_COUNTDOWN: begin
        if (tick_1hz) begin
          if (cnt_is_one) begin
            phase_d       = PH_PLAY;
            cnt_load      = 1'b1;
            cnt_load_val  = PL_LOAD;
            score_clear_d = 1'b1;
          end else begin
            cnt_tick = 1'b1;
          end
        end
      end
      PH_PLAY: begin
        if (tick_1hz) begin
          if (cnt_is_one) begin
            phase_d      = PH_OVER;
            cnt_load     = 1'b1;
            cnt_load_val = 8'd0;
            final_d      = score_in;
            round_done_d = 1'b1;
          end else begin
            cnt_tick = 1'b1;
          end
        end
      end
      PH_OVER: begin
        // start outranks a coincident tick; ticks never touch the counter here.
        if (start) begin
          phase_d       = PH_COUNTDOWN;
          cnt_load      = 1'b1;
          cnt_load_val  = CD_LOAD;
          score_clear_d = 1'b1;
`ifdef GAME_HIGH_SCORE_EN
          show_high_d   = 1'b0;
`endif
        end
`ifdef GAME_HIGH_SCORE_EN
        else if (tick_1hz) begin
          show_high_d = ~show_high_q;
        end
`endif
      end
      default: begin
        // Unreachable encoding: restart the round cleanly.
        phase_d       = PH_COUNTDOWN;
        cnt_load      = 1'b1;
        cnt_load_val  = CD_LOAD;
        score_clear_d = 1'b1;
`ifdef GAME_HIGH_SCORE_EN
        show_high_d   = 1'b0;
`endif
      end
    endcase

    case (phase_d)
      PH_COUNTDOWN: display_d = SCORE_W'(cnt_next);
      PH_PLAY:      display_d = score_in;
      default: begin
`ifdef GAME_HIGH_SCORE_EN
        display_d = show_high_d ? high_d : final_d;
`else
        display_d = final_d;
`endif
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PH_COUNTDOWN;
      final_q       <= '0;
      display_q     <= SCORE_W'(CD_LOAD);
      score_clear_q <= 1'b1;
      round_done_q  <= 1'b0;
      play_q        <= 1'b0;
`ifdef GAME_HIGH_SCORE_EN
      high_q        <= '0;
      show_high_q   <= 1'b0;
`endif
    end else begin
      phase_q       <= phase_d;
      final_q       <= final_d;
      display_q     <= display_d;
      score_clear_q <= score_clear_d;
      round_done_q  <= round_done_d;
      play_q        <= (phase_d == PH_PLAY);
`ifdef GAME_HIGH_SCORE_EN
      high_q        <= high_d;
      show_high_q   <= show_high_d;
`endif
    end
  end

  assign phase         = phase_q;
  assign time_left     = cnt_q;
  assign display_value = display_q;
  assign score_clear   = score_clear_q;
  assign score_enable  = play_q;
  assign led_enable    = play_q;
  assign round_done    = round_done_q;
`ifdef GAME_HIGH_SCORE_EN
  assign high_score    = high_q;
`else
  assign high_score    = '0;
`endif

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed testbench for game_phase_sequencer (COUNTDOWN_SECS=5, PLAY_SECS=30).
module tb_game_phase_sequencer;

  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick_1hz;
  logic          start;
  logic [SW-1:0] score_in;
  logic [1:0]    phase;
  logic [7:0]    time_left;
  logic [SW-1:0] display_value;
  logic          score_clear;
  logic          score_enable;
  logic          led_enable;
  logic          round_done;
  logic [SW-1:0] high_score;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  game_phase_sequencer #(
    .COUNTDOWN_SECS (5),
    .PLAY_SECS      (30),
    .SCORE_W        (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .start         (start),
    .score_in      (score_in),
    .phase         (phase),
    .time_left     (time_left),
    .display_value (display_value),
    .score_clear   (score_clear),
    .score_enable  (score_enable),
    .led_enable    (led_enable),
    .round_done    (round_done),
    .high_score    (high_score)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // From a fresh COUNTDOWN, play a full round scoring s and settle in OVER.
  task automatic run_round(input logic [SW-1:0] s);
    score_in = s;
    for (int i = 0; i < 35; i++) do_tick();
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL rst_phase got %0d exp 0", phase); end
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL rst_time got %0d exp 5", time_left); end
    n_checks++; if (display_value !== 32'd5) begin n_errors++; $display("FAIL rst_disp got %0d exp 5", display_value); end
    n_checks++; if (score_clear !== 1'b1) begin n_errors++; $display("FAIL rst_clear got %0b exp 1", score_clear); end
    n_checks++; if (score_enable !== 1'b0) begin n_errors++; $display("FAIL rst_sen got %0b exp 0", score_enable); end
    n_checks++; if (led_enable !== 1'b0) begin n_errors++; $display("FAIL rst_led got %0b exp 0", led_enable); end
    n_checks++; if (round_done !== 1'b0) begin n_errors++; $display("FAIL rst_done got %0b exp 0", round_done); end
    n_checks++; if (high_score !== 32'd0) begin n_errors++; $display("FAIL rst_high got %0d exp 0", high_score); end
    reset = 1'b0;
    cycle();
    n_checks++; if (score_clear !== 1'b0) begin n_errors++; $display("FAIL rel_clear got %0b exp 0", score_clear); end
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL rel_phase got %0d exp 0", phase); end
    cycle();
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL idle_time got %0d exp 5", time_left); end
  endtask

  task automatic test_start_ignored_countdown();
    do_start();
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL cd_start_phase got %0d exp 0", phase); end
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL cd_start_time got %0d exp 5", time_left); end
    n_checks++; if (score_clear !== 1'b0) begin n_errors++; $display("FAIL cd_start_clear got %0b exp 0", score_clear); end
  endtask

  task automatic test_countdown();
    for (int i = 0; i < 4; i++) begin
      do_tick();
      n_checks++; if (time_left !== 8'(4 - i)) begin n_errors++; $display("FAIL cd_time[%0d] got %0d exp %0d", i, time_left, 4 - i); end
      n_checks++; if (display_value !== 32'(4 - i)) begin n_errors++; $display("FAIL cd_disp[%0d] got %0d exp %0d", i, display_value, 4 - i); end
      n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL cd_phase[%0d] got %0d exp 0", i, phase); end
    end
    do_tick();
    n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL to_play_phase got %0d exp 1", phase); end
    n_checks++; if (time_left !== 8'd30) begin n_errors++; $display("FAIL to_play_time got %0d exp 30", time_left); end
    n_checks++; if (score_clear !== 1'b1) begin n_errors++; $display("FAIL to_play_clear got %0b exp 1", score_clear); end
    n_checks++; if (score_enable !== 1'b1) begin n_errors++; $display("FAIL to_play_sen got %0b exp 1", score_enable); end
    n_checks++; if (led_enable !== 1'b1) begin n_errors++; $display("FAIL to_play_led got %0b exp 1", led_enable); end
    cycle();
    n_checks++; if (score_clear !== 1'b0) begin n_errors++; $display("FAIL play_clear_end got %0b exp 0", score_clear); end
    n_checks++; if (time_left !== 8'd30) begin n_errors++; $display("FAIL play_hold_time got %0d exp 30", time_left); end
  endtask

  task automatic test_start_ignored_play();
    do_start();
    n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL pl_start_phase got %0d exp 1", phase); end
    n_checks++; if (time_left !== 8'd30) begin n_errors++; $display("FAIL pl_start_time got %0d exp 30", time_left); end
  endtask

  task automatic test_play();
    score_in = 32'd17;
    cycle();
    n_checks++; if (display_value !== 32'd17) begin n_errors++; $display("FAIL play_disp got %0d exp 17", display_value); end
    for (int i = 0; i < 29; i++) do_tick();
    n_checks++; if (time_left !== 8'd1) begin n_errors++; $display("FAIL play_last_time got %0d exp 1", time_left); end
    n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL play_last_phase got %0d exp 1", phase); end
    do_tick();
    n_checks++; if (phase !== 2'b10) begin n_errors++; $display("FAIL over_phase got %0d exp 2", phase); end
    n_checks++; if (round_done !== 1'b1) begin n_errors++; $display("FAIL over_done got %0b exp 1", round_done); end
    n_checks++; if (time_left !== 8'd0) begin n_errors++; $display("FAIL over_time got %0d exp 0", time_left); end
    n_checks++; if (display_value !== 32'd17) begin n_errors++; $display("FAIL over_disp got %0d exp 17", display_value); end
    n_checks++; if (score_enable !== 1'b0) begin n_errors++; $display("FAIL over_sen got %0b exp 0", score_enable); end
    n_checks++; if (led_enable !== 1'b0) begin n_errors++; $display("FAIL over_led got %0b exp 0", led_enable); end
    cycle();
    n_checks++; if (round_done !== 1'b0) begin n_errors++; $display("FAIL over_done_end got %0b exp 0", round_done); end
    score_in = 32'd99;
    cycle();
    cycle();
    n_checks++; if (display_value !== 32'd17) begin n_errors++; $display("FAIL over_hold_disp got %0d exp 17", display_value); end
    do_tick();
    n_checks++; if (time_left !== 8'd0) begin n_errors++; $display("FAIL over_tick_time got %0d exp 0", time_left); end
    n_checks++; if (phase !== 2'b10) begin n_errors++; $display("FAIL over_tick_phase got %0d exp 2", phase); end
    n_checks++; if (display_value !== 32'd17) begin n_errors++; $display("FAIL over_tick_disp got %0d exp 17", display_value); end
  endtask

  task automatic test_start_over();
    do_start();
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL restart_phase got %0d exp 0", phase); end
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL restart_time got %0d exp 5", time_left); end
    n_checks++; if (score_clear !== 1'b1) begin n_errors++; $display("FAIL restart_clear got %0b exp 1", score_clear); end
    n_checks++; if (display_value !== 32'd5) begin n_errors++; $display("FAIL restart_disp got %0d exp 5", display_value); end
    cycle();
    n_checks++; if (score_clear !== 1'b0) begin n_errors++; $display("FAIL restart_clear_end got %0b exp 0", score_clear); end
  endtask

  task automatic test_start_tick_same();
    score_in = 32'd3;
    for (int i = 0; i < 35; i++) do_tick();
    n_checks++; if (phase !== 2'b10) begin n_errors++; $display("FAIL st_pre_phase got %0d exp 2", phase); end
    start    = 1'b1;
    tick_1hz = 1'b1;
    cycle();
    start    = 1'b0;
    tick_1hz = 1'b0;
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL st_phase got %0d exp 0", phase); end
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL st_time got %0d exp 5", time_left); end
    n_checks++; if (score_clear !== 1'b1) begin n_errors++; $display("FAIL st_clear got %0b exp 1", score_clear); end
    cycle();
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL st_hold_time got %0d exp 5", time_left); end
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < 5; i++) do_tick();
    for (int i = 0; i < 18; i++) do_tick();
    n_checks++; if (time_left !== 8'd12) begin n_errors++; $display("FAIL mid_time got %0d exp 12", time_left); end
    n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL mid_phase got %0d exp 1", phase); end
    reset = 1'b1;
    cycle();
    n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL mrst_phase got %0d exp 0", phase); end
    n_checks++; if (time_left !== 8'd5) begin n_errors++; $display("FAIL mrst_time got %0d exp 5", time_left); end
    n_checks++; if (led_enable !== 1'b0) begin n_errors++; $display("FAIL mrst_led got %0b exp 0", led_enable); end
    n_checks++; if (score_enable !== 1'b0) begin n_errors++; $display("FAIL mrst_sen got %0b exp 0", score_enable); end
    n_checks++; if (display_value !== 32'd5) begin n_errors++; $display("FAIL mrst_disp got %0d exp 5", display_value); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_high_score();
    logic [SW-1:0] exp_h1, exp_h2, exp_h3, exp_alt;
`ifdef GAME_HIGH_SCORE_EN
    exp_h1 = 32'd8; exp_h2 = 32'd8; exp_h3 = 32'd11; exp_alt = 32'd8;
`else
    exp_h1 = 32'd0; exp_h2 = 32'd0; exp_h3 = 32'd0; exp_alt = 32'd5;
`endif
    run_round(32'd8);
    n_checks++; if (high_score !== exp_h1) begin n_errors++; $display("FAIL hs_r1 got %0d exp %0d", high_score, exp_h1); end
    n_checks++; if (display_value !== 32'd8) begin n_errors++; $display("FAIL hs_r1_disp got %0d exp 8", display_value); end
    do_start();
    run_round(32'd5);
    n_checks++; if (high_score !== exp_h2) begin n_errors++; $display("FAIL hs_r2 got %0d exp %0d", high_score, exp_h2); end
    n_checks++; if (display_value !== 32'd5) begin n_errors++; $display("FAIL hs_alt0 got %0d exp 5", display_value); end
    do_tick();
    n_checks++; if (display_value !== exp_alt) begin n_errors++; $display("FAIL hs_alt1 got %0d exp %0d", display_value, exp_alt); end
    do_tick();
    n_checks++; if (display_value !== 32'd5) begin n_errors++; $display("FAIL hs_alt2 got %0d exp 5", display_value); end
    do_start();
    run_round(32'd11);
    n_checks++; if (high_score !== exp_h3) begin n_errors++; $display("FAIL hs_r3 got %0d exp %0d", high_score, exp_h3); end
    n_checks++; if (display_value !== 32'd11) begin n_errors++; $display("FAIL hs_r3_disp got %0d exp 11", display_value); end
  endtask

  initial begin
    reset    = 1'b1;
    tick_1hz = 1'b0;
    start    = 1'b0;
    score_in = '0;
    test_reset();
    test_start_ignored_countdown();
    test_countdown();
    test_start_ignored_play();
    test_play();
    test_start_over();
    test_start_tick_same();
    test_reset_mid_play();
    test_high_score();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
